// File: rtl/bus8_rr_arbiter.sv
// Round-robin arbiter and byte sequencer for the shared 8-bit DLX bus.
// Grants one of four requesters per burst and registers its byte onto the bus.
module bus8_rr_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  REQ,
    input  logic [31:0] DIN,
    output logic [3:0]  GNT,
    output logic [1:0]  OWNER,
    output logic        BUSY,
    output logic [7:0]  BUS_O,
    output logic        BUS_VALID
);

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  bus_q, bus_d;
    logic        valid_q, valid_d;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;
    logic [7:0]  own_byte;

    // First requester at or after the priority pointer, wrapping mod 4.
    always_comb begin
        pick  = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign own_byte = DIN[{owner_q, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        bus_d   = bus_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (|REQ) begin
                    gnt_d   = 4'b0001 << pick;
                    owner_d = pick;
                    cnt_d   = 4'd0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (REQ[owner_q]) begin
                    bus_d   = own_byte;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    // Last beat still captures data before handing back.
                    if (cnt_q == LAST) begin
                        gnt_d   = 4'b0000;
                        ptr_d   = owner_q + 2'd1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end else begin
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            bus_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
        end
    end

    assign GNT       = gnt_q;
    assign OWNER     = owner_q;
    assign BUSY      = (state_q == OWN);
    assign BUS_O     = bus_q;
    assign BUS_VALID = valid_q;

endmodule
